// File: rtl/msfsms_sig_interface.sv
// Signal-interface stage for the MSFSM converter controller: synchronises Ri/Ai into
// single-cycle event pulses and turns the composition's output events back into levels.
module msfsms_sig_interface #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic Ri_in,
    input  logic Ai_in,
    output logic Ri_PLUS,
    output logic Ri_MINUS,
    output logic Ai_PLUS,
    output logic Ai_MINUS,
    output logic Ai_PLUSa,
    output logic Ai_MINUSa,
    input  logic Ro_PLUS,
    input  logic Ro_PLUSa,
    input  logic Ro_MINUS,
    input  logic Ro_MINUSa,
    input  logic Ao_PLUS,
    input  logic Ao_MINUS,
    input  logic x_PLUS,
    input  logic x_MINUS,
    output logic Ro,
    output logic Ao,
    output logic x,
    output logic protocol_err
);

    logic [SYNC_STAGES-1:0] ri_sync, ai_sync;
    logic                   ri_prev, ai_prev;
    logic                   ai_ph, ro_ph;

    logic ri_s, ai_s;
    logic ri_rise, ri_fall, ai_rise, ai_fall;

    assign ri_s    = ri_sync[SYNC_STAGES-1];
    assign ai_s    = ai_sync[SYNC_STAGES-1];
    assign ri_rise =  ri_s & ~ri_prev;
    assign ri_fall = ~ri_s &  ri_prev;
    assign ai_rise =  ai_s & ~ai_prev;
    assign ai_fall = ~ai_s &  ai_prev;

    // Returns {error, next_level} for a simple set/clear level.
    function automatic logic [1:0] level_step(input logic lvl, input logic set, input logic clr);
        logic [1:0] r;
        r = {1'b0, lvl};
        if (set && clr)  r = {1'b1, lvl};
        else if (set)    r = lvl  ? {1'b1, lvl} : 2'b01;
        else if (clr)    r = !lvl ? {1'b1, lvl} : 2'b00;
        return r;
    endfunction

    logic [2:0] ro_cnt;
    logic       ro_next, ro_ph_next, ro_err;
    logic [1:0] ao_step, x_step;

    assign ro_cnt  = {2'b0, Ro_PLUS} + {2'b0, Ro_PLUSa} + {2'b0, Ro_MINUS} + {2'b0, Ro_MINUSa};
    assign ao_step = level_step(Ao, Ao_PLUS, Ao_MINUS);
    assign x_step  = level_step(x, x_PLUS, x_MINUS);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ro_next    = Ro;
        ro_ph_next = ro_ph;
        ro_err     = 1'b0;
        if (ro_cnt > 3'd1) begin
            ro_err = 1'b1;
        end else if (Ro_PLUS) begin
            if (!ro_ph && !Ro) ro_next = 1'b1;
            else               ro_err  = 1'b1;
        end else if (Ro_PLUSa) begin
            if (ro_ph && !Ro)  ro_next = 1'b1;
            else               ro_err  = 1'b1;
        end else if (Ro_MINUS) begin
            if (!ro_ph && Ro) begin
                ro_next    = 1'b0;
                ro_ph_next = 1'b1;
            end else begin
                ro_err = 1'b1;
            end
        end else if (Ro_MINUSa) begin
            if (ro_ph && Ro) begin
                ro_next    = 1'b0;
                ro_ph_next = 1'b0;
            end else begin
                ro_err = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ri_sync      <= '0;
            ai_sync      <= '0;
            ri_prev      <= 1'b0;
            ai_prev      <= 1'b0;
            ai_ph        <= 1'b0;
            ro_ph        <= 1'b0;
            Ri_PLUS      <= 1'b0;
            Ri_MINUS     <= 1'b0;
            Ai_PLUS      <= 1'b0;
            Ai_MINUS     <= 1'b0;
            Ai_PLUSa     <= 1'b0;
            Ai_MINUSa    <= 1'b0;
            Ro           <= 1'b0;
            Ao           <= 1'b0;
            x            <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            ri_sync   <= {ri_sync[SYNC_STAGES-2:0], Ri_in};
            ai_sync   <= {ai_sync[SYNC_STAGES-2:0], Ai_in};
            ri_prev   <= ri_s;
            ai_prev   <= ai_s;
            Ri_PLUS   <= ri_rise;
            Ri_MINUS  <= ri_fall;
            Ai_PLUS   <= ai_rise & ~ai_ph;
            Ai_MINUS  <= ai_fall & ~ai_ph;
            Ai_PLUSa  <= ai_rise &  ai_ph;
            Ai_MINUSa <= ai_fall &  ai_ph;
            if (ai_fall) ai_ph <= ~ai_ph;

            Ro    <= ro_next;
            ro_ph <= ro_ph_next;
            Ao    <= ao_step[0];
            x     <= x_step[0];
            if (ro_err || ao_step[1] || x_step[1]) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_msfsms_sig_interface.sv
// Directed bench for msfsms_sig_interface: input pulse timing, Ai phase classification,
// output level handling, protocol errors and asynchronous reset.
module tb_msfsms_sig_interface;

    logic clk = 1'b0;
    logic reset;
    logic Ri_in, Ai_in;
    logic Ri_PLUS, Ri_MINUS, Ai_PLUS, Ai_MINUS, Ai_PLUSa, Ai_MINUSa;
    logic Ro, Ao, x, protocol_err;
    logic [7:0] ev;

    localparam logic [7:0] RO_P  = 8'h01;
    localparam logic [7:0] RO_PA = 8'h02;
    localparam logic [7:0] RO_M  = 8'h04;
    localparam logic [7:0] RO_MA = 8'h08;
    localparam logic [7:0] AO_P  = 8'h10;
    localparam logic [7:0] X_P   = 8'h40;

    int checks = 0;
    int errors = 0;
    int cnt[6];
    int first[6];
    logic [5:0] pulses;

    assign pulses = {Ai_MINUSa, Ai_PLUSa, Ai_MINUS, Ai_PLUS, Ri_MINUS, Ri_PLUS};

    always #5 clk = ~clk;

    msfsms_sig_interface #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .Ri_in(Ri_in), .Ai_in(Ai_in),
        .Ri_PLUS(Ri_PLUS), .Ri_MINUS(Ri_MINUS), .Ai_PLUS(Ai_PLUS), .Ai_MINUS(Ai_MINUS),
        .Ai_PLUSa(Ai_PLUSa), .Ai_MINUSa(Ai_MINUSa),
        .Ro_PLUS(ev[0]), .Ro_PLUSa(ev[1]), .Ro_MINUS(ev[2]), .Ro_MINUSa(ev[3]),
        .Ao_PLUS(ev[4]), .Ao_MINUS(ev[5]), .x_PLUS(ev[6]), .x_MINUS(ev[7]),
        .Ro(Ro), .Ao(Ao), .x(x), .protocol_err(protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles, counting each pulse and the first cycle (1-based) it was seen.
    task automatic run(input int n);
        for (int j = 0; j < 6; j++) begin
            cnt[j]   = 0;
            first[j] = -1;
        end
        for (int i = 1; i <= n; i++) begin
            tick();
            for (int j = 0; j < 6; j++) begin
                if (pulses[j]) begin
                    cnt[j]++;
                    if (first[j] < 0) first[j] = i;
                end
            end
        end
    endtask

    task automatic fire(input logic [7:0] e);
        ev = e;
        tick();
        ev = '0;
    endtask

    initial begin
        reset = 1'b0;
        Ri_in = 1'b0;
        Ai_in = 1'b0;
        ev    = '0;

        tick();
        tick();
        check("reset_state", {28'd0, Ro, Ao, x, protocol_err} | {26'd0, pulses}, 32'd0);
        reset = 1'b1;
        run(10);
        check("idle_pulses", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] + cnt[5], 0);
        check("idle_levels", {Ro, Ao, x, protocol_err}, 4'b0000);

        // Ri rise before edge 1 of the window -> pulse after edge 3
        Ri_in = 1'b1;
        run(12);
        check("ri_plus_cycle", first[0], 3);
        check("ri_plus_count", cnt[0], 1);
        check("ri_minus_none", cnt[1], 0);
        Ri_in = 1'b0;
        run(12);
        check("ri_minus_cycle", first[1], 3);
        check("ri_minus_count", cnt[1], 1);

        // Ai phase classification: PLUS, MINUS, PLUSa, MINUSa, PLUS
        Ai_in = 1'b1; run(8);
        check("ai1_plus", first[2], 3);
        check("ai1_total", cnt[2] + cnt[3] + cnt[4] + cnt[5], 1);
        Ai_in = 1'b0; run(8);
        check("ai2_minus", first[3], 3);
        check("ai2_total", cnt[2] + cnt[3] + cnt[4] + cnt[5], 1);
        Ai_in = 1'b1; run(8);
        check("ai3_plusa", first[4], 3);
        check("ai3_total", cnt[2] + cnt[3] + cnt[4] + cnt[5], 1);
        Ai_in = 1'b0; run(8);
        check("ai4_minusa", first[5], 3);
        check("ai4_total", cnt[2] + cnt[3] + cnt[4] + cnt[5], 1);
        Ai_in = 1'b1; run(8);
        check("ai5_plus", first[2], 3);
        check("ai5_total", cnt[2] + cnt[3] + cnt[4] + cnt[5], 1);

        // Ro legal cycle through both phases
        fire(RO_P);  check("ro_set_ph0", Ro, 1'b1);
        tick(); tick(); check("ro_hold", Ro, 1'b1);
        fire(RO_M);  check("ro_clr_ph0", Ro, 1'b0);
        tick(); tick();
        fire(RO_PA); check("ro_set_ph1", Ro, 1'b1);
        tick(); tick();
        fire(RO_MA); check("ro_clr_ph1", Ro, 1'b0);
        check("ro_seq_err", protocol_err, 1'b0);

        // Concurrent events on different signals
        fire(AO_P | X_P);
        check("ao_x_levels", {Ao, x}, 2'b11);
        check("ao_x_err", protocol_err, 1'b0);

        // Wrong-phase Ro event
        fire(RO_PA);
        check("wrong_ph_ro", Ro, 1'b0);
        check("wrong_ph_err", protocol_err, 1'b1);
        tick(); tick(); tick();
        check("err_sticky", protocol_err, 1'b1);
        fire(RO_P);
        check("ro_after_err", Ro, 1'b1);

        // Asynchronous reset mid-cycle with Ri_in and Ai_in high
        Ri_in = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_reset", {28'd0, Ro, Ao, x, protocol_err} | {26'd0, pulses}, 32'd0);
        tick();
        reset = 1'b1;
        run(6);
        check("release_ri_plus", first[0], 3);
        check("release_ai_plus", first[2], 3);
        check("release_ri_count", cnt[0], 1);

        // Redundant set on Ao
        fire(AO_P);
        check("ao_first_set_err", protocol_err, 1'b0);
        fire(AO_P);
        check("ao_double_level", Ao, 1'b1);
        check("ao_double_err", protocol_err, 1'b1);

        // Two Ro events in one cycle
        reset = 1'b0;
        tick();
        reset = 1'b1;
        fire(RO_P | RO_MA);
        check("ro_multi_level", Ro, 1'b0);
        check("ro_multi_err", protocol_err, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
